// File: rtl/fp32_pkg.sv
// Shared single-precision field constants, FSM states and operand classes
// for the sequential FP divider.
package fp32_pkg;
  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_NORM, ST_DONE} state_t;
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;
endpackage

// File: rtl/fpd_32bit_seq_if.sv
// Start/busy/done handshake and operand/result bus of the FP divider.
interface fpd_32bit_seq_if;
  logic        start;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        busy;
  logic        done;
  logic [31:0] x3;
  logic        div_by_zero;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  modport master (output start, x1, x2,
                  input  busy, done, x3, div_by_zero, invalid, overflow, underflow);
  modport slave  (input  start, x1, x2,
                  output busy, done, x3, div_by_zero, invalid, overflow, underflow);
endinterface

// File: rtl/fpd_mant_div_iter.sv
// Restoring mantissa divider: {1,m1}/{1,m2}, one quotient bit per step, MSB first.
module fpd_mant_div_iter #(
  parameter int unsigned QBITS = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [22:0]      m1,
  input  logic [22:0]      m2,
  output logic             last,
  output logic             rem_zero,
  output logic [QBITS-1:0] quo
);
  localparam int unsigned      CW      = $clog2(QBITS);
  localparam logic [CW-1:0]    CNT_END = CW'(QBITS - 1);

  logic [24:0]   rem;
  logic [23:0]   dvs;
  logic [CW-1:0] cnt;
  logic [25:0]   diff;
  logic [24:0]   rem_nxt;
  logic          qbit;

  always_comb begin
    diff    = {1'b0, rem} - {2'b00, dvs};
    qbit    = ~diff[25];
    rem_nxt = qbit ? diff[24:0] : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      quo <= '0;
    end else if (load) begin
      rem <= {2'b01, m1};
      dvs <= {1'b1, m2};
      cnt <= '0;
      quo <= '0;
    end else if (step) begin
      rem <= rem_nxt << 1;
      cnt <= cnt + CW'(1);
      quo <= {quo[QBITS-2:0], qbit};
    end
  end

  assign last     = (cnt == CNT_END);
  assign rem_zero = (rem == '0);
endmodule

// File: rtl/fpd_32bit_seq.sv
// Iterative IEEE-754 single-precision divider x3 = x1 / x2 (denormals as zero).
// Define FPD_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fpd_32bit_seq
  import fp32_pkg::*;
#(
  parameter int unsigned QBITS     = 26,
  parameter logic [31:0] NAN_VALUE = QNAN
) (
  input logic             clk,
  input logic             rst_n,
  fpd_32bit_seq_if.slave  bus
);
  localparam logic signed [9:0] E_BIAS = 10'(BIAS);
  localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

  state_t state, state_next;
  cls_t   c1, c2;

  logic              sign_r;
  logic signed [9:0] exp_r;
  logic [31:0]       x3_r;
  logic              dbz_r, inv_r, ovf_r, unf_r;

  logic              s_in, special, spec_inv, spec_dbz;
  logic [31:0]       spec_x3;
  logic              div_load, div_step, div_last, rem_zero;
  logic [QBITS-1:0]  quo;

  logic [QBITS-1:0]  q_n;
  logic signed [9:0] e_n;
  logic [MAN_W-1:0]  mant;
  logic [31:0]       norm_x3;
  logic              norm_ovf, norm_unf;
`ifdef FPD_ROUND_NEAREST_EN
  logic              guard, sticky;
  logic [MAN_W:0]    man_inc;
`endif

  function automatic cls_t classify(input logic [31:0] v);
    if (v[30:23] == '0)      return CL_ZERO;
    else if (v[30:23] == '1) return (v[22:0] != '0) ? CL_NAN : CL_INF;
    else                     return CL_NORM;
  endfunction

  always_comb begin
    c1       = classify(bus.x1);
    c2       = classify(bus.x2);
    s_in     = bus.x1[31] ^ bus.x2[31];
    spec_inv = (c1 == CL_NAN) || (c2 == CL_NAN) ||
               (c1 == CL_ZERO && c2 == CL_ZERO) || (c1 == CL_INF && c2 == CL_INF);
    spec_dbz = (c1 == CL_NORM) && (c2 == CL_ZERO);
    special  = !(c1 == CL_NORM && c2 == CL_NORM);
    if (spec_inv)                           spec_x3 = NAN_VALUE;
    else if (c1 == CL_INF || c2 == CL_ZERO) spec_x3 = {s_in, 8'hFF, 23'd0};
    else                                    spec_x3 = {s_in, 31'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        state_next = special ? ST_DONE : ST_DIV;
        div_load   = !special;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_next = ST_NORM;
      end
      ST_NORM: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  fpd_mant_div_iter #(.QBITS(QBITS)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .m1       (bus.x1[22:0]),
    .m2       (bus.x2[22:0]),
    .last     (div_last),
    .rem_zero (rem_zero),
    .quo      (quo)
  );

  // A quotient MSB of 0 means m1 < m2: renormalise by one place and borrow from e.
  always_comb begin
    q_n  = quo[QBITS-1] ? quo : {quo[QBITS-2:0], 1'b0};
    e_n  = quo[QBITS-1] ? exp_r : exp_r - 10'sd1;
    mant = q_n[QBITS-2 -: MAN_W];
`ifdef FPD_ROUND_NEAREST_EN
    guard   = q_n[QBITS-2-MAN_W];
    sticky  = !rem_zero;
    man_inc = {1'b0, mant} + 24'd1;
    if (guard && (sticky || mant[0])) begin
      if (man_inc[MAN_W]) begin
        mant = '0;
        e_n  = e_n + 10'sd1;
      end else begin
        mant = man_inc[MAN_W-1:0];
      end
    end
`endif
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (e_n >= E_MAX) begin
      norm_ovf = 1'b1;
      norm_x3  = {sign_r, 8'hFF, 23'd0};
    end else if (e_n <= 10'sd0) begin
      norm_unf = 1'b1;
      norm_x3  = {sign_r, 31'd0};
    end else begin
      norm_x3  = {sign_r, e_n[EXP_W-1:0], mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
      exp_r  <= '0;
      x3_r   <= '0;
      dbz_r  <= 1'b0;
      inv_r  <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      sign_r <= s_in;
      exp_r  <= $signed({2'b00, bus.x1[30:23]}) - $signed({2'b00, bus.x2[30:23]}) + E_BIAS;
      dbz_r  <= special && spec_dbz;
      inv_r  <= special && spec_inv;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
      if (special) x3_r <= spec_x3;
    end else if (state == ST_NORM) begin
      x3_r  <= norm_x3;
      ovf_r <= norm_ovf;
      unf_r <= norm_unf;
    end
  end

  assign bus.busy        = (state == ST_DIV) || (state == ST_NORM);
  assign bus.done        = (state == ST_DONE);
  assign bus.x3          = x3_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.invalid     = inv_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = unf_r;
endmodule

// File: tb/tb_fpd_32bit_seq.sv
// Directed and randomized checks of fpd_32bit_seq against an arithmetic reference model.
module tb_fpd_32bit_seq;
  localparam int QB = 26;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpd_32bit_seq_if bus ();

  fpd_32bit_seq #(.QBITS(QB), .NAN_VALUE(32'h7FC00000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] obs_flags;
  assign obs_flags = {bus.div_by_zero, bus.invalid, bus.overflow, bus.underflow};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {special, dbz, inv, ovf, unf, x3}, derived from IEEE rules with integer division.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    int                ea, eb, e;
    logic              s;
    bit                za, zb, ia, ib, na, nb;
    longint unsigned   num, den, q, r;
    logic [63:0]       qv;
    logic [22:0]       mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);   zb = (eb == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && !na;
    ib = (eb == 255) && !nb;
    if (na || nb || (za && zb) || (ia && ib)) return {1'b1, 4'b0100, 32'h7FC00000};
    if (zb && !ia)                            return {1'b1, 4'b1000, s, 8'hFF, 23'd0};
    if (ia)                                   return {1'b1, 4'b0000, s, 8'hFF, 23'd0};
    if (za || ib)                             return {1'b1, 4'b0000, s, 31'd0};
    num = {40'd1, a[22:0]} << 25;
    den = {40'd1, b[22:0]};
    q   = num / den;
    r   = num % den;
    e   = ea - eb + 127;
    if (q < (64'd1 << 25)) begin
      q = q << 1;
      e = e - 1;
    end
    qv   = q;
    mant = qv[24:2];
`ifdef FPD_ROUND_NEAREST_EN
    if (qv[1] && (r != 0 || mant[0])) begin
      if (mant == 23'h7FFFFF) begin
        mant = 23'd0;
        e    = e + 1;
      end else begin
        mant = mant + 23'd1;
      end
    end
`endif
    if (e >= 255) return {1'b0, 4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, 4'b0001, s, 31'd0};
    return {1'b0, 4'b0000, s, 8'(e), mant};
  endfunction

  function automatic logic [31:0] rnd_op();
    int          sel;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 11);
    m   = 23'($urandom);
    case (sel)
      0:       e = 8'd0;
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'd0; end
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ex3, input logic [3:0] exf, input int exlat);
    int cyc     = 0;
    bit seen    = 0;
    bit busy_ok = 1;
    @(negedge clk);
    bus.x1    = a;
    bus.x2    = b;
    bus.start = 1'b1;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.x1    = $urandom;
      bus.x2    = $urandom;
      if (bus.done) seen = 1;
      else if (!bus.busy) busy_ok = 0;
    end
    check({tag, ":latency"}, 64'(cyc), 64'(exlat));
    check({tag, ":busy"}, {63'd0, busy_ok && !bus.busy}, 64'd1);
    check({tag, ":result"}, {28'd0, obs_flags, bus.x3}, {28'd0, exf, ex3});
    @(negedge clk);
    check({tag, ":pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  task automatic run_rand(input int idx);
    logic [31:0] a, b;
    logic [36:0] m;
    a = rnd_op();
    b = rnd_op();
    m = model(a, b);
    run_op($sformatf("rand%0d_%h_%h", idx, a, b), a, b, m[31:0], m[35:32], m[36] ? 1 : QB + 2);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          cyc;
    int          first_done;
    int          second_done;
    logic [31:0] first_x3;
    logic [31:0] second_x3;
    logic [31:0] third_exp;
    bus.start = 1'b0;
    bus.x1    = '0;
    bus.x2    = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, bus.busy, bus.done, obs_flags, bus.x3}, 64'd0);
    rst_n = 1'b1;

`ifdef FPD_ROUND_NEAREST_EN
    third_exp = 32'h3EAAAAAB;
`else
    third_exp = 32'h3EAAAAAA;
`endif
    run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, third_exp,    4'b0000, 28);
    run_op("five_by_zero", 32'h40A00000, 32'h00000000, 32'h7F800000, 4'b1000, 1);
    run_op("nzero_nzero",  32'h80000000, 32'h80000000, 32'h7FC00000, 4'b0100, 1);
    run_op("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28);
    run_op("underflow",    32'h00800000, 32'h40800000, 32'h00000000, 4'b0001, 28);
    run_op("nan_in",       32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b0100, 1);
    run_op("inf_by_two",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    run_op("m3_by_inf",    32'hC0400000, 32'h7F800000, 32'h80000000, 4'b0000, 1);
    run_op("inf_by_zero",  32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1);
    run_op("inf_by_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0100, 1);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, third_exp,    4'b0000, 28);

    // Asynchronous reset in cycle 10 of a division.
    @(negedge clk);
    bus.x1    = 32'h40C00000;
    bus.x2    = 32'h40000000;
    bus.start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_busy", {63'd0, bus.busy}, 64'd1);
    check("mid_held_x3", {32'd0, bus.x3}, {32'd0, third_exp});
    rst_n = 1'b0;
    #1;
    check("async_reset", {27'd0, bus.busy, bus.done, obs_flags, bus.x3}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

    // start held high; operands change at cycle 5.
    @(negedge clk);
    bus.x1      = 32'h40C00000;
    bus.x2      = 32'h40000000;
    bus.start   = 1'b1;
    cyc         = 0;
    first_done  = -1;
    second_done = -1;
    first_x3    = '0;
    second_x3   = '0;
    while (cyc < 100 && second_done < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        bus.x1 = 32'h3F800000;
        bus.x2 = 32'h40400000;
      end
      if (cyc == 29) check("held_idle_gap", {62'd0, bus.busy, bus.done}, 64'd0);
      if (bus.done) begin
        if (first_done < 0) begin
          first_done = cyc;
          first_x3   = bus.x3;
        end else begin
          second_done = cyc;
          second_x3   = bus.x3;
        end
      end
    end
    bus.start = 1'b0;
    check("held_first_cycle",  64'(first_done),  64'd28);
    check("held_first_x3",     {32'd0, first_x3},  64'h40400000);
    check("held_second_cycle", 64'(second_done), 64'd57);
    check("held_second_x3",    {32'd0, second_x3}, {32'd0, third_exp});
    @(negedge clk);

    for (int i = 0; i < 40; i++) run_rand(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpd_32bit_seq.md
Name: fpd_32bit_seq

Overview:
- Iterative IEEE-754 single-precision divider, x3 = x1 / x2; the inverse companion of the existing combinational 32-bit FP multiplier.
- Uses a start/busy/done handshake and computes one mantissa quotient bit per clock with restoring division.
- Sits beside the multiplier in the FP datapath. Operands are captured at start; the result is held until the next start.

Parameters:
- QBITS, 26, quotient bits generated: 24 mantissa + 1 normalisation + 1 guard; must be >= 26; sets latency.
- NAN_VALUE, 32'h7FC00000, canonical quiet NaN returned for every invalid case.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset: one clock; asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- x1  input  32  dividend, captured when start is accepted
- x2  input  32  divisor, captured when start is accepted
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  single-cycle pulse, result valid
- x3  output  32  quotient, registered, held until next acceptance
- div_by_zero  output  1  finite nonzero / zero; valid with done, held
- invalid  output  1  NaN input, 0/0 or inf/inf; valid with done, held
- overflow  output  1  result exponent >= 255; valid with done, held
- underflow  output  1  result exponent <= 0, flushed to zero; valid with done, held

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; busy, done, x3 and all flags = 0.
  - Takes effect immediately, including mid-division; the in-flight operation is discarded.
- States: IDLE -> (DIV -> NORM) -> DONE -> IDLE.
- IDLE:
  - If start = 1: register operands, clear flags, classify both operands.
  - Special case goes to DONE; otherwise load divider and go to DIV.
- Classification (denormal inputs are treated as zero):
  - NaN in, 0/0, inf/inf: NAN_VALUE, invalid = 1.
  - finite/0: signed inf, div_by_zero = 1.
  - inf/finite: signed inf.
  - 0/nonzero or finite/inf: signed zero.
  - Sign is always s1 ^ s2, except NaN, which has sign 0.
- DIV:
  - Runs exactly QBITS cycles.
  - Partial remainder starts at {1,m1}; divisor is {1,m2}. Each cycle produces one quotient bit, MSB first: subtract, keep if non-negative, shift remainder left.
- NORM (1 cycle):
  - Exponent is a 10-bit signed value: e = E1 - E2 + 127.
  - If quotient MSB = 0: shift the quotient left 1 and e = e - 1.
  - Mantissa is the 23 bits below the leading 1. Guard is the next bit; sticky = (remainder != 0).
  - Default rounding is truncation.
  - If e >= 255: signed inf, overflow = 1.
  - If e <= 0: signed zero, underflow = 1.
- DONE (1 cycle): done = 1, busy = 0, x3 and flags updated in this cycle; next state IDLE.
- Latency, with start accepted in cycle 0:
  - special case: done in cycle 1.
  - normal: DIV in cycles 1..QBITS, NORM in QBITS+1, done in cycle QBITS+2 (28 at default).
- Throughput: one operation per QBITS+3 cycles.
- start while busy or in DONE is ignored, not queued; operand changes while busy have no effect.

Optional Feature:
- Macro: FPD_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in NORM.
  - Increment when guard & (sticky | lsb).
  - A mantissa carry-out sets the mantissa to 0 and increments e, with the overflow check applied afterwards. NORM stays 1 cycle.
- Undefined: truncation; guard/sticky logic is not synthesised.

Decomposition:
- Shared package fp32_pkg:
  - BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC00000.
  - Field widths (EXP_W = 8, MAN_W = 23).
  - State enum {IDLE, DIV, NORM, DONE}.
  - Operand class enum {ZERO, NORM, INF, NAN}.
- One sub-module: fpd_mant_div_iter.
  - Holds the restoring remainder/quotient registers and the iteration counter.
  - Interface: load, step, remainder-zero, quotient out.
- Classification stays inline in the top level.

Test Plan:
- 6.0 / 2.0 (0x40C00000 / 0x40000000) -> x3 = 0x40400000; done exactly in cycle 28; all flags 0; busy high cycles 1..27.
- 1.0 / 3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAA without the macro; 0x3EAAAAAB with FPD_ROUND_NEAREST_EN.
- 5.0 / +0 (0x40A00000 / 0x00000000) -> 0x7F800000, div_by_zero = 1, done in cycle 1; 0x80000000 / 0x80000000 -> 0x7FC00000, invalid = 1.
- 2^127 / 0.25 (0x7F000000 / 0x3E800000) -> 0x7F800000, overflow = 1; 2^-126 / 4.0 (0x00800000 / 0x40800000) -> 0x00000000, underflow = 1.
- Pulse rst_n low in cycle 10 of a division -> busy, done, x3 and flags are 0 immediately. A new 6.0/2.0 start after release completes correctly with 28-cycle latency.
- start held high through an operation with x1/x2 changed at cycle 5 -> first result reflects the captured operands; the second operation is accepted only in the IDLE cycle after DONE.
